// File: rtl/apb_fifo_bridge_gen_if.sv
// APB3/APB4 completer-side bus bundle for apb_fifo_bridge_gen.
// The FIFO side stays on plain ports because it belongs to the remote clock domain.
interface apb_fifo_bridge_gen_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   paddr;
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [DATA_W-1:0]   pwdata;
   logic [DATA_W/8-1:0] pstrb;
   logic                pready;
   logic [DATA_W-1:0]   prdata;
   logic                pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_fifo_bridge_gen.sv
// APB slave bridging NREG registers across a clock boundary via external async FIFOs:
// writes are byte-merged against a shadow bank and pushed, remote updates drain into the bank.
module apb_fifo_bridge_gen #(
   parameter int              ADDR_W    = 16,
   parameter int              DATA_W    = 32,
   parameter int              NREG      = 4,
   parameter int              TAG_W     = 2,
   parameter int              BASE_ADDR = 1,
   parameter logic [NREG-1:0] RO_MASK   = 4'b0100,
   parameter int              TIMEOUT   = 64
) (
   input  logic                    pclk,
   input  logic                    preset_n,
   apb_fifo_bridge_gen_if.slave    apb,
   input  logic                    fifo_write_full,
   output logic [TAG_W+DATA_W-1:0] fifo_write_data,
   output logic                    fifo_write_inc,
   input  logic                    fifo_read_empty,
   input  logic [TAG_W+DATA_W-1:0] fifo_read_data,
   output logic                    fifo_read_inc,
   output logic [7:0]              drop_cnt
);

   localparam int NBYTE = DATA_W / 8;
   localparam int NSLOT = 1 << TAG_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [NSLOT-1:0] RO_PAD = NSLOT'(RO_MASK);

   typedef enum logic [1:0] {IDLE, WAIT_FULL, DONE} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          wait_q, wait_d;
   logic                      pready_q, pready_d;
   logic                      pslverr_q, pslverr_d;
   logic [DATA_W-1:0]         prdata_q, prdata_d;
   logic                      winc_d;
   logic [TAG_W+DATA_W-1:0]   wdata_d;

   // Slots at or above NREG only exist so any TAG_W-bit index is in range; they stay zero.
   logic [DATA_W-1:0]         shadow [NSLOT];

   logic [ADDR_W-1:0]         idx_full;
   logic                      in_range;
   logic [TAG_W-1:0]          idx;
   logic                      wr_legal;
   logic                      access;
   logic [DATA_W-1:0]         sel_shadow;
   logic [DATA_W-1:0]         merged;
   logic [TAG_W-1:0]          rd_tag;
   logic                      drain_go;

   assign idx_full   = apb.paddr - ADDR_W'(BASE_ADDR);
   assign in_range   = (apb.paddr >= ADDR_W'(BASE_ADDR)) && (idx_full < ADDR_W'(NREG));
   assign idx        = idx_full[TAG_W-1:0];
   assign wr_legal   = in_range && !RO_PAD[idx];
   assign access     = apb.psel && apb.penable && !pready_q;
   assign sel_shadow = shadow[idx];

   always_comb begin
      merged = '0;
      for (int b = 0; b < NBYTE; b++)
         merged[8*b +: 8] = apb.pstrb[b] ? apb.pwdata[8*b +: 8] : sel_shadow[8*b +: 8];
   end

   // NOTE: every output of this block gets a default first so no path leaves a latch behind.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      winc_d    = 1'b0;
      wdata_d   = fifo_write_data;
      case (state_q)
         IDLE: begin
            if (access) begin
               state_d  = DONE;
               pready_d = 1'b1;
               if (!apb.pwrite) begin
                  if (in_range) prdata_d  = sel_shadow;
                  else          pslverr_d = 1'b1;
               end else if (!wr_legal) begin
                  pslverr_d = 1'b1;
               end else if (fifo_write_full) begin
                  state_d  = WAIT_FULL;
                  pready_d = 1'b0;
                  wait_d   = '0;
               end else begin
                  winc_d  = 1'b1;
                  wdata_d = {idx, merged};
               end
            end
         end
         WAIT_FULL: begin
            if (!fifo_write_full) begin
               state_d  = DONE;
               pready_d = 1'b1;
               winc_d   = 1'b1;
               wdata_d  = {idx, merged};
            end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = DONE;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q         <= IDLE;
         wait_q          <= '0;
         pready_q        <= 1'b0;
         pslverr_q       <= 1'b0;
         prdata_q        <= '0;
         fifo_write_inc  <= 1'b0;
         fifo_write_data <= '0;
      end else begin
         state_q         <= state_d;
         wait_q          <= wait_d;
         pready_q        <= pready_d;
         pslverr_q       <= pslverr_d;
         prdata_q        <= prdata_d;
         fifo_write_inc  <= winc_d;
         fifo_write_data <= wdata_d;
      end
   end

   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign apb.prdata  = prdata_q;

   // An APB access wins over the drain, so a read never sees the bank change under it.
   assign rd_tag   = fifo_read_data[TAG_W+DATA_W-1 -: TAG_W];
   assign drain_go = (state_q == IDLE) && !access && !fifo_read_empty && !fifo_read_inc;

   // NOTE: the shadow bank is reset as flops because reads must return zero before any update.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         for (int i = 0; i < NSLOT; i++) shadow[i] <= '0;
         fifo_read_inc <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         fifo_read_inc <= drain_go;
         if (drain_go) begin
            if ({1'b0, rd_tag} < (TAG_W+1)'(NREG))
               shadow[rd_tag] <= fifo_read_data[DATA_W-1:0];
            else if (drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule
